// File: rtl/smbus_pkg.sv
// Shared definitions for the SMBus PEC sequencer: CRC-8 constants, state encoding
// and the bytewise CRC-8 update (poly 0x07, MSB first).
package smbus_pkg;

    localparam logic [7:0] SMBUS_PEC_POLY = 8'h07;
    localparam logic [7:0] SMBUS_PEC_INIT = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StTxPec,
        StRxPec,
        StDone
    } pec_state_e;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ SMBUS_PEC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/smbus_pec_seq.sv
// SMBus PEC transaction sequencer: counts transaction bytes, accumulates CRC-8, appends
// or checks the PEC byte. Optional error counter under SMBUS_PEC_SEQ_ERR_STATS_EN.
module smbus_pec_seq
    import smbus_pkg::*;
#(
    parameter int unsigned LEN_W = 8
`ifdef SMBUS_PEC_SEQ_ERR_STATS_EN
    ,
    parameter int unsigned ERR_CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_pec_en,
    input  logic             txn_start,
    input  logic             txn_dir,
    input  logic [LEN_W-1:0] txn_len,
    input  logic             txn_abort,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [7:0]       pec_byte,
    output logic             pec_valid,
    input  logic             pec_ready,
    output logic [7:0]       crc_out,
    output logic             busy,
    output logic             done,
    output logic             pec_err
`ifdef SMBUS_PEC_SEQ_ERR_STATS_EN
    ,
    input  logic                 err_cnt_clr,
    output logic [ERR_CNT_W-1:0] pec_err_cnt
`endif
);

    pec_state_e       state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    // Zero naturally encodes 2^LEN_W: the first decrement wraps to all-ones.
    logic [LEN_W-1:0] count_q, count_d;
    logic             pec_en_q, pec_en_d;
    logic             dir_q, dir_d;
    logic             pec_err_q, pec_err_d;
    logic             hs;
    logic             aborting;

    assign hs       = byte_valid && byte_ready;
    assign aborting = txn_abort && (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            crc_q     <= SMBUS_PEC_INIT;
            count_q   <= '0;
            pec_en_q  <= 1'b0;
            dir_q     <= 1'b0;
            pec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            pec_en_q  <= pec_en_d;
            dir_q     <= dir_d;
            pec_err_q <= pec_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        count_d   = count_q;
        pec_en_d  = pec_en_q;
        dir_d     = dir_q;
        pec_err_d = pec_err_q;
        if (aborting) begin
            state_d = StIdle;
            crc_d   = SMBUS_PEC_INIT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (txn_start) begin
                        pec_en_d  = cfg_pec_en;
                        dir_d     = txn_dir;
                        crc_d     = SMBUS_PEC_INIT;
                        pec_err_d = 1'b0;
                        count_d   = txn_len;
                        state_d   = StAccum;
                    end
                end
                StAccum: begin
                    if (hs) begin
                        crc_d   = crc8_update(crc_q, byte_in);
                        count_d = count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) begin
                            if (!pec_en_q) begin
                                state_d = StDone;
                            end else if (!dir_q) begin
                                state_d = StTxPec;
                            end else begin
                                state_d = StRxPec;
                            end
                        end
                    end
                end
                StTxPec: begin
                    if (pec_ready) begin
                        state_d = StDone;
                    end
                end
                StRxPec: begin
                    if (hs) begin
                        pec_err_d = (byte_in != crc_q);
                        state_d   = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        pec_valid  = 1'b0;
        pec_byte   = 8'h00;
        done       = 1'b0;
        busy       = (state_q != StIdle);
        unique case (state_q)
            StAccum: byte_ready = 1'b1;
            StRxPec: byte_ready = 1'b1;
            StTxPec: begin
                pec_valid = 1'b1;
                pec_byte  = crc_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign crc_out = crc_q;
    assign pec_err = pec_err_q;

`ifdef SMBUS_PEC_SEQ_ERR_STATS_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 rx_mismatch;

    assign rx_mismatch = (state_q == StRxPec) && hs && !txn_abort && (byte_in != crc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (rx_mismatch && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign pec_err_cnt = err_cnt_q;
`endif

endmodule
